turing_engine: RTL and testbench
================================

TURING_ENGINE -- requirements
Module: turing_engine

Interface
REQ-001 SHALL have parameter IN_W, default 6, width of input_data; IN_W >= STATE_W and IN_W >= SYM_W.
REQ-002 SHALL have parameter SYM_W, default 2, tape symbol width; symbol 0 is blank.
REQ-003 SHALL have parameter TAPE_DEPTH, default 64, tape cells; ADDR_W = $clog2(TAPE_DEPTH).
REQ-004 SHALL have parameter NUM_STATES, default 16; STATE_W = $clog2(NUM_STATES); state NUM_STATES-1 is HALT; state 0 is start.
REQ-005 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port input_data, input, IN_W, field or symbol value latched on a Next edge.
REQ-008 SHALL have port Next, input, 1, load-strobe or single-step request, rising-edge detected.
REQ-009 SHALL have port Done, input, 1, ends the current load phase, rising-edge detected.
REQ-010 SHALL have port Run, input, 1, level; while high in EXEC, steps back-to-back.
REQ-011 SHALL have port currState, output, STATE_W, current machine state.
REQ-012 SHALL have port display_out, output, STATE_W+ADDR_W+SYM_W, {currState, head, tape[head]}.
REQ-013 SHALL have port Compute_done, output, 1, sticky halt indication.
REQ-014 SHALL have port error, output, 1, sticky tape-boundary fault.
REQ-015 SHALL have port step_count, output, 16, executed-step counter (see Configuration).

Function
REQ-016 SHALL treat Next and Done as events only on a 0->1 transition between consecutive clocks; held levels produce one event.
REQ-017 SHALL sequence phases LOAD_PROG -> LOAD_TAPE -> EXEC -> HALTED, each transition on a Done event or halt.
REQ-018 LOAD_PROG: SHALL store one field per Next event into entry index {state,symbol}, ascending, field order write_sym, move, next_state; after three fields the entry index increments.
REQ-019 Move encoding SHALL be 0=left, 1=right, 2 or 3=stay.
REQ-020 Entries not written before Done SHALL keep default {write 0, stay, next HALT}; Next events beyond the last entry SHALL be ignored.
REQ-021 LOAD_TAPE: each Next event SHALL write input_data[SYM_W-1:0] to tape[addr], addr increments from 0; events at addr TAPE_DEPTH are ignored.
REQ-022 Done in LOAD_TAPE SHALL enter EXEC with head 0, currState 0.
REQ-023 A step SHALL take exactly 2 cycles: FETCH (read entry for {currState, tape[head]}), EXEC (write tape[head], move head, update currState); outputs reflect the result on the cycle after EXEC.
REQ-024 A step SHALL start on a Next event, or every 2 cycles while Run is high; Next events during an in-flight step SHALL be dropped.
REQ-025 Reaching HALT SHALL set Compute_done, enter HALTED, and ignore further Next, Done, Run until reset.
REQ-026 A left move at head 0 or right move at head TAPE_DEPTH-1 SHALL complete the write, leave head unchanged, set error and Compute_done, and enter HALTED.
REQ-027 Simultaneous Next and Done events SHALL act as Done only.
REQ-028 Run SHALL be ignored outside EXEC.

Reset
REQ-029 On reset: phase LOAD_PROG, all indices 0, head 0, currState 0, every tape cell 0, every table entry default, Compute_done 0, error 0, step_count 0, edge detectors cleared.
REQ-030 Reset SHALL take priority over all events, including mid-step and mid-load.

Configuration
REQ-031 With TM_STEP_COUNT_EN defined, step_count SHALL increment once per completed step, saturating at 16'hFFFF; undefined, step_count SHALL be constant 0 and the counter absent.

Verification (NUM_STATES=4, SYM_W=2, TAPE_DEPTH=8, IN_W=6)
REQ-032 Load entry0 {0,2,3}, entry1 {2,1,0}, Done; tape 1,1,1,0, Done; Run=1 -> after 8 cycles Compute_done=1, tape 2,2,2,0, head 3, currState 3, step_count 4 (macro on).
REQ-033 Same program, Run=0, Next pulsed 3 cycles high per step -> one step per pulse; after first, display_out = {0,1,1}.
REQ-034 Entry1 move=0, tape 1 -> first step sets error=1, Compute_done=1, head 0, tape[0]=2.
REQ-035 9 Next events in LOAD_TAPE with values 1..9 -> tape holds 1,2,3,0,1,2,3,0; 9th ignored.
REQ-036 reset asserted during step 2 of REQ-032 -> next cycle all outputs 0, phase LOAD_PROG, tape cleared.
REQ-037 Build without TM_STEP_COUNT_EN, rerun REQ-032 -> step_count stays 0, all other results identical.

Source files
------------

// File: rtl/turing_engine.sv
// rtl/turing_engine.sv - Table-driven Turing machine: program/tape load, then single-step or free-run execution.
// Optional feature macro: TM_STEP_COUNT_EN (saturating executed-step counter on step_count).
module turing_engine #(
    parameter int IN_W       = 6,
    parameter int SYM_W      = 2,
    parameter int TAPE_DEPTH = 64,
    parameter int NUM_STATES = 16
) (
    input  logic                                                   clock,
    input  logic                                                   reset,
    input  logic [IN_W-1:0]                                        input_data,
    input  logic                                                   Next,
    input  logic                                                   Done,
    input  logic                                                   Run,
    output logic [$clog2(NUM_STATES)-1:0]                          currState,
    output logic [$clog2(NUM_STATES)+$clog2(TAPE_DEPTH)+SYM_W-1:0] display_out,
    output logic                                                   Compute_done,
    output logic                                                   error,
    output logic [15:0]                                            step_count
);
    localparam int STATE_W = $clog2(NUM_STATES);
    localparam int ADDR_W  = $clog2(TAPE_DEPTH);
    localparam int E_W     = STATE_W + SYM_W;
    localparam int NUM_ENT = NUM_STATES << SYM_W;
    localparam logic [STATE_W-1:0] HALT_ST  = STATE_W'(NUM_STATES - 1);
    localparam logic [E_W-1:0]     LAST_ENT = E_W'(NUM_ENT - 1);
    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W+1)'(TAPE_DEPTH);
    localparam logic [ADDR_W-1:0]  HEAD_MAX = ADDR_W'(TAPE_DEPTH - 1);
    localparam logic [1:0]         MV_L     = 2'd0;
    localparam logic [1:0]         MV_R     = 2'd1;
    localparam logic [1:0]         MV_STAY  = 2'd2;

    typedef enum logic [2:0] {
        S_PROG,
        S_TAPE,
        S_IDLE,
        S_FETCH,
        S_STEP,
        S_HALT
    } phase_t;

    phase_t             r_ph;
    phase_t             w_ph_nx;
    logic               r_next_q;
    logic               r_done_q;
    logic               w_next_ev;
    logic               w_done_ev;
    logic [SYM_W-1:0]   r_tbl_sym [NUM_ENT];
    logic [1:0]         r_tbl_mv  [NUM_ENT];
    logic [STATE_W-1:0] r_tbl_nxt [NUM_ENT];
    logic [SYM_W-1:0]   r_tape    [TAPE_DEPTH];
    logic [E_W-1:0]     r_pidx;
    logic [1:0]         r_fld;
    logic               r_prog_full;
    logic [ADDR_W:0]    r_taddr;
    logic [ADDR_W-1:0]  r_head;
    logic [STATE_W-1:0] r_state;
    logic [SYM_W-1:0]   r_e_sym;
    logic [1:0]         r_e_mv;
    logic [STATE_W-1:0] r_e_nxt;
    logic               r_cdone;
    logic               r_err;
    logic [E_W-1:0]     w_idx;
    logic               w_fault;
    logic               w_stop;
    logic               w_unused_bits;

    // A simultaneous Done swallows the Next event.
    assign w_done_ev = Done & ~r_done_q;
    assign w_next_ev = Next & ~r_next_q & ~w_done_ev;

    assign w_idx   = {r_state, r_tape[r_head]};
    assign w_fault = ((r_e_mv == MV_L) && (r_head == '0)) ||
                     ((r_e_mv == MV_R) && (r_head == HEAD_MAX));
    assign w_stop  = w_fault || (r_e_nxt == HALT_ST);

    assign w_unused_bits = ^input_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ph <= S_PROG;
        end else begin
            r_ph <= w_ph_nx;
        end
    end

    always_comb begin
        w_ph_nx = r_ph;
        case (r_ph)
            S_PROG:  if (w_done_ev) w_ph_nx = S_TAPE;
            S_TAPE:  if (w_done_ev) w_ph_nx = S_IDLE;
            S_IDLE:  if (w_next_ev || Run) w_ph_nx = S_FETCH;
            S_FETCH: w_ph_nx = S_STEP;
            S_STEP: begin
                if (w_stop)   w_ph_nx = S_HALT;
                else if (Run) w_ph_nx = S_FETCH;
                else          w_ph_nx = S_IDLE;
            end
            S_HALT:  w_ph_nx = S_HALT;
            default: w_ph_nx = S_PROG;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_next_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_pidx      <= '0;
            r_fld       <= 2'd0;
            r_prog_full <= 1'b0;
            r_taddr     <= '0;
            r_head      <= '0;
            r_state     <= '0;
            r_e_sym     <= '0;
            r_e_mv      <= MV_STAY;
            r_e_nxt     <= '0;
            r_cdone     <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NUM_ENT; i++) begin
                r_tbl_sym[i] <= '0;
                r_tbl_mv[i]  <= MV_STAY;
                r_tbl_nxt[i] <= HALT_ST;
            end
            for (int i = 0; i < TAPE_DEPTH; i++) begin
                r_tape[i] <= '0;
            end
        end else begin
            r_next_q <= Next;
            r_done_q <= Done;
            case (r_ph)
                S_PROG: begin
                    if (w_next_ev && !r_prog_full) begin
                        case (r_fld)
                            2'd0:    r_tbl_sym[r_pidx] <= input_data[SYM_W-1:0];
                            2'd1:    r_tbl_mv[r_pidx]  <= input_data[1:0];
                            default: r_tbl_nxt[r_pidx] <= input_data[STATE_W-1:0];
                        endcase
                        if (r_fld == 2'd2) begin
                            r_fld <= 2'd0;
                            if (r_pidx == LAST_ENT) r_prog_full <= 1'b1;
                            else                    r_pidx <= r_pidx + 1'b1;
                        end else begin
                            r_fld <= r_fld + 1'b1;
                        end
                    end
                end
                S_TAPE: begin
                    if (w_next_ev && (r_taddr < DEPTH_L)) begin
                        r_tape[r_taddr[ADDR_W-1:0]] <= input_data[SYM_W-1:0];
                        r_taddr <= r_taddr + 1'b1;
                    end
                    if (w_done_ev) begin
                        r_head  <= '0;
                        r_state <= '0;
                    end
                end
                S_FETCH: begin
                    r_e_sym <= r_tbl_sym[w_idx];
                    r_e_mv  <= r_tbl_mv[w_idx];
                    r_e_nxt <= r_tbl_nxt[w_idx];
                end
                S_STEP: begin
                    // A boundary fault still commits the write and state update, only the head stays put.
                    r_tape[r_head] <= r_e_sym;
                    r_state        <= r_e_nxt;
                    if (!w_fault) begin
                        if (r_e_mv == MV_L)      r_head <= r_head - 1'b1;
                        else if (r_e_mv == MV_R) r_head <= r_head + 1'b1;
                    end
                    if (w_fault) r_err   <= 1'b1;
                    if (w_stop)  r_cdone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef TM_STEP_COUNT_EN
    logic [15:0] r_steps;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_steps <= 16'd0;
        end else if ((r_ph == S_STEP) && (r_steps != 16'hFFFF)) begin
            r_steps <= r_steps + 16'd1;
        end
    end

    assign step_count = r_steps;
`else
    assign step_count = 16'd0;
`endif

    assign currState    = r_state;
    assign display_out  = {r_state, r_head, r_tape[r_head]};
    assign Compute_done = r_cdone;
    assign error        = r_err;

endmodule

// File: tb/tb_turing_engine.sv
// tb/tb_turing_engine.sv - Randomized self-checking bench for turing_engine against a behavioural model.
`timescale 1ns/1ps
module tb_turing_engine;
    localparam int NS = 4;
    localparam int SW = 2;
    localparam int TD = 8;
    localparam int IW = 6;
    localparam int NE = NS * (1 << SW);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] input_data = '0;
    logic          Next = 1'b0;
    logic          Done = 1'b0;
    logic          Run = 1'b0;
    logic [1:0]    currState;
    logic [6:0]    display_out;
    logic          Compute_done;
    logic          error;
    logic [15:0]   step_count;

    turing_engine #(.IN_W(IW), .SYM_W(SW), .TAPE_DEPTH(TD), .NUM_STATES(NS)) dut (
        .clock(clock),
        .reset(reset),
        .input_data(input_data),
        .Next(Next),
        .Done(Done),
        .Run(Run),
        .currState(currState),
        .display_out(display_out),
        .Compute_done(Compute_done),
        .error(error),
        .step_count(step_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int m_sym [NE];
    int m_mv  [NE];
    int m_nxt [NE];
    int m_tape[TD];
    int m_head, m_st, m_steps, m_pcnt, m_taddr;
    bit m_err, m_cd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NE; i++) begin
            m_sym[i] = 0; m_mv[i] = 2; m_nxt[i] = NS - 1;
        end
        for (int i = 0; i < TD; i++) m_tape[i] = 0;
        m_head = 0; m_st = 0; m_steps = 0; m_pcnt = 0; m_taddr = 0;
        m_err = 0; m_cd = 0;
    endfunction

    function automatic void m_field(input int v);
        if (m_pcnt < NE * 3) begin
            case (m_pcnt % 3)
                0:       m_sym[m_pcnt / 3] = v % (1 << SW);
                1:       m_mv[m_pcnt / 3]  = v % 4;
                default: m_nxt[m_pcnt / 3] = v % NS;
            endcase
            m_pcnt++;
        end
    endfunction

    function automatic void m_tape_wr(input int v);
        if (m_taddr < TD) begin
            m_tape[m_taddr] = v % (1 << SW);
            m_taddr++;
        end
    endfunction

    function automatic void m_step();
        int  idx, mv;
        bit  fault;
        if (m_cd) return;
        idx = m_st * (1 << SW) + m_tape[m_head];
        mv  = m_mv[idx];
        m_tape[m_head] = m_sym[idx];
        fault = (mv == 0 && m_head == 0) || (mv == 1 && m_head == TD - 1);
        if (!fault) begin
            if (mv == 0)      m_head--;
            else if (mv == 1) m_head++;
        end
        m_st = m_nxt[idx];
        if (m_steps < 65535) m_steps++;
        if (fault) begin m_err = 1; m_cd = 1; end
        if (m_st == NS - 1) m_cd = 1;
    endfunction

    function automatic bit m_halts_within(input int n);
        int sv_tape[TD];
        int sv_head, sv_st, sv_steps;
        bit sv_err, sv_cd, r;
        sv_tape = m_tape; sv_head = m_head; sv_st = m_st; sv_steps = m_steps;
        sv_err = m_err; sv_cd = m_cd;
        for (int k = 0; k < n && !m_cd; k++) m_step();
        r = m_cd;
        m_tape = sv_tape; m_head = sv_head; m_st = sv_st; m_steps = sv_steps;
        m_err = sv_err; m_cd = sv_cd;
        return r;
    endfunction

    function automatic int exp_steps();
`ifdef TM_STEP_COUNT_EN
        return m_steps;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        reset = 1'b1; Next = 1'b0; Done = 1'b0; Run = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic send(input int v, input int hold);
        input_data = IW'(v);
        Next = 1'b1;
        repeat (hold) @(posedge clock);
        #1 Next = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        @(posedge clock); #1;
        Done = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic send_both(input int v);
        input_data = IW'(v);
        Next = 1'b1; Done = 1'b1;
        @(posedge clock); #1;
        Next = 1'b0; Done = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic step_next(input int hold);
        send(0, hold);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag);
        @(negedge clock);
        chk({tag, ".state"}, 32'(currState), m_st);
        chk({tag, ".disp"}, 32'(display_out), m_st * 32 + m_head * 4 + m_tape[m_head]);
        chk({tag, ".cdone"}, 32'(Compute_done), 32'(m_cd));
        chk({tag, ".err"}, 32'(error), 32'(m_err));
        chk({tag, ".steps"}, 32'(step_count), exp_steps());
        @(posedge clock); #1;
    endtask

    task automatic check_tape(input string tag);
        for (int i = 0; i < TD; i++) chk({tag, ".tape"}, 32'(dut.r_tape[i]), m_tape[i]);
    endtask

    task automatic run_to_halt(input string tag);
        int c = 0;
        Run = 1'b1;
        while (!Compute_done && c < 300) begin
            @(negedge clock);
            c++;
        end
        Run = 1'b0;
        chk({tag, ".halt_seen"}, 32'(Compute_done), 1);
        @(posedge clock); #1;
        for (int k = 0; k < 200 && !m_cd; k++) m_step();
    endtask

    task automatic load_std(input int mv1, input int tp[$]);
        int f[6];
        f = '{0, 2, 3, 2, mv1, 0};
        for (int i = 0; i < 6; i++) begin send(f[i], 1); m_field(f[i]); end
        pulse_done();
        foreach (tp[i]) begin send(tp[i], 1); m_tape_wr(tp[i]); end
        pulse_done();
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_all("rst");

        // Free-run of the reference program, then confirm the halted machine ignores stimulus
        do_reset();
        load_std(1, '{1, 1, 1, 0});
        check_all("r32.ld");
        run_to_halt("r32");
        check_all("r32");
        check_tape("r32");
        chk("r32.head", 32'(display_out[4:2]), 3);
        chk("r32.state_c", 32'(currState), 3);
        send(1, 1);
        pulse_done();
        Run = 1'b1; repeat (4) @(posedge clock); #1 Run = 1'b0;
        check_all("hlt");

        do_reset();
        load_std(1, '{1, 1, 1, 0});
        for (int k = 0; k < 4; k++) begin
            step_next(3);
            m_step();
            if (k == 0) chk("r33.first", 32'(display_out), 32'h05);
            check_all("r33");
        end
        check_tape("r33");

        do_reset();
        load_std(0, '{1});
        step_next(1);
        m_step();
        check_all("r34");
        check_tape("r34");
        chk("r34.err_c", 32'(error), 1);

        do_reset();
        pulse_done();
        for (int v = 1; v <= 9; v++) begin send(v, 1); m_tape_wr(v); end
        check_tape("r35");
        pulse_done();
        run_to_halt("r35");
        check_all("r35");

        // Next and Done together must close the program phase without storing a field
        do_reset();
        send(1, 1); m_field(1);
        send(1, 1); m_field(1);
        send(0, 1); m_field(0);
        send_both(2);
        send(0, 1); m_tape_wr(0);
        pulse_done();
        run_to_halt("both");
        check_all("both");
        check_tape("both");

        do_reset();
        load_std(1, '{1, 1, 1, 0});
        Run = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1; Run = 1'b0;
        @(posedge clock); #1 reset = 1'b0;
        m_reset();
        check_all("r36");
        check_tape("r36");
        chk("r36.disp0", 32'(display_out), 0);
        load_std(1, '{1, 1, 1, 0});
        run_to_halt("r37");
        check_all("r37");
        check_tape("r37");

        for (int t = 0; t < 12; t++) begin
            int nent, ntape, v;
            do_reset();
            nent = $urandom_range(1, NE);
            for (int e = 0; e < nent * 3; e++) begin
                v = $urandom_range(0, 63);
                send(v, 1); m_field(v);
            end
            if (nent == NE) begin
                send(5, 1); m_field(5);
                send(6, 1); m_field(6);
            end
            pulse_done();
            ntape = $urandom_range(0, 10);
            for (int i = 0; i < ntape; i++) begin
                v = $urandom_range(0, 63);
                send(v, 1); m_tape_wr(v);
            end
            pulse_done();
            if ((t % 2 == 0) && m_halts_within(60)) begin
                run_to_halt("rnd.run");
                check_all("rnd.run");
            end else begin
                for (int k = 0; k < 10 && !m_cd; k++) begin
                    step_next($urandom_range(1, 3));
                    m_step();
                    check_all("rnd.step");
                end
            end
            check_tape("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
